// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM write-port bundle for ram_loader.
// The master side is the loader: it sinks the stream and drives the RAM strobes.
interface ram_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bas;
  logic       wsa;
  logic [7:0] bis;
  logic       ws;

  modport master (
    input  in_data, in_valid,
    output in_ready, bas, wsa, bis, ws
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, bas, wsa, bis, ws
  );
endinterface

// File: rtl/ram_loader.sv
// Boot loader: takes a length/payload/checksum frame from a ready/valid byte stream
// and writes the payload into RAM through the MAR-set and data-write strobes.
module ram_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter bit         CHECK_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  ram_loader_if.master bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err,
  output logic         busy
);

  typedef enum logic [3:0] {
    StIdle, StLen, StByte, StSetA, StHoldA, StWr, StRelW, StCsum, StDone, StErr
  } state_e;

  state_e     state;
  logic [7:0] addr;
  logic [7:0] sum;
  logic [8:0] cnt;  // 9 bits so a zero length byte can stand for 256

  logic xfer;
  assign xfer = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      addr         <= 8'h00;
      sum          <= 8'h00;
      cnt          <= 9'd0;
      bus.in_ready <= 1'b0;
      bus.bas      <= 8'h00;
      bus.wsa      <= 1'b0;
      bus.bis      <= 8'h00;
      bus.ws       <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone, StErr: begin
          if (start) begin
            state        <= StLen;
            addr         <= BASE_ADDR;
            sum          <= 8'h00;
            bus.in_ready <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b1;
          end
        end
        StLen: begin
          if (xfer) begin
            cnt   <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            state <= StByte;
          end
        end
        StByte: begin
          if (xfer) begin
            bus.bis      <= bus.in_data;
            sum          <= sum + bus.in_data;
            bus.in_ready <= 1'b0;
            bus.bas      <= addr;
            bus.wsa      <= 1'b1;
            state        <= StSetA;
          end
        end
        StSetA: begin
          bus.wsa <= 1'b0;
          state   <= StHoldA;
        end
        StHoldA: begin
          bus.ws <= 1'b1;
          state  <= StWr;
        end
        StWr: begin
          bus.ws <= 1'b0;
          state  <= StRelW;
        end
        StRelW: begin
          addr <= addr + 8'd1;
          cnt  <= cnt - 9'd1;
          if (cnt != 9'd1) begin
            bus.in_ready <= 1'b1;
            state        <= StByte;
          end else if (CHECK_EN) begin
            bus.in_ready <= 1'b1;
            state        <= StCsum;
          end else begin
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            state    <= StDone;
          end
        end
        StCsum: begin
          if (xfer) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.in_data == sum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= StDone;
            end else begin
              err      <= 1'b1;
              cpu_hold <= 1'b1;
              state    <= StErr;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
